// File: rtl/apb_timer_sched.sv
// APB master that time-shares one apb_timer among NREQ requesters:
// round-robin grant, LOAD write, CTRL start write, STATUS polling, then ack.
module apb_timer_sched #(
    parameter int NREQ     = 4,
    parameter int POLL_GAP = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_delay,
    output logic [NREQ-1:0]   ack,
    output logic              err,
    output logic              busy,
    output logic [2:0]        grant_id,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [7:0]        PADDR,
    output logic [7:0]        PWDATA,
    input  logic [7:0]        PRDATA,
    input  logic              PREADY
);
    localparam logic [7:0] ADDR_LOAD   = 8'h00;
    localparam logic [7:0] ADDR_CTRL   = 8'h04;
    localparam logic [7:0] ADDR_STATUS = 8'h08;
    localparam int         WW          = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_GAP, S_FINISH} state_t;
    typedef enum logic [1:0] {OP_LOAD, OP_START, OP_POLL} op_t;

    state_t          r_state;
    op_t             r_op;
    logic [2:0]      r_ptr;
    logic [WW-1:0]   r_wait;
    logic [3:0]      r_gap;
    logic [NREQ-1:0] r_ack;
    logic            r_err;
    logic            r_busy;
    logic [2:0]      r_grant_id;
    logic            r_psel;
    logic            r_penable;
    logic            r_pwrite;
    logic [7:0]      r_paddr;
    logic [7:0]      r_pwdata;

    logic [7:0]      w_req_ext;
    logic [63:0]     w_delay_ext;
    logic [2:0]      w_idx;
    logic [2:0]      w_cand;
    logic [2:0]      w_next_ptr;
    logic [7:0]      w_delay;

    assign w_req_ext   = 8'(req);
    assign w_delay_ext = 64'(req_delay);

    // Walk offsets from farthest to nearest so the first set bit at or after
    // the pointer is the one left standing.
    always_comb begin
        w_idx  = '0;
        w_cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = 3'((int'(r_ptr) + k) % NREQ);
            if (w_req_ext[w_cand]) begin
                w_idx = w_cand;
            end
        end
    end

    assign w_next_ptr = (int'(w_idx) == NREQ - 1) ? 3'd0 : w_idx + 3'd1;
    assign w_delay    = w_delay_ext[{w_idx, 3'b000} +: 8];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state    <= S_IDLE;
            r_op       <= OP_LOAD;
            r_ptr      <= '0;
            r_wait     <= '0;
            r_gap      <= '0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_grant_id <= '0;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_grant_id <= w_idx;
                        r_busy     <= 1'b1;
                        r_ptr      <= w_next_ptr;
                        // A zero load would never raise done, so skip the timer.
                        if (w_delay == 8'd0) begin
                            r_state <= S_FINISH;
                            r_ack   <= NREQ'(1) << w_idx;
                        end else begin
                            r_op      <= OP_LOAD;
                            r_state   <= S_SETUP;
                            r_psel    <= 1'b1;
                            r_penable <= 1'b0;
                            r_pwrite  <= 1'b1;
                            r_paddr   <= ADDR_LOAD;
                            r_pwdata  <= w_delay;
                        end
                    end
                end
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
                    r_wait    <= '0;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        if (r_op == OP_LOAD) begin
                            r_op      <= OP_START;
                            r_state   <= S_SETUP;
                            r_penable <= 1'b0;
                            r_pwrite  <= 1'b1;
                            r_paddr   <= ADDR_CTRL;
                            r_pwdata  <= 8'h01;
                        end else if (r_op == OP_POLL && PRDATA[0]) begin
                            r_state   <= S_FINISH;
                            r_psel    <= 1'b0;
                            r_penable <= 1'b0;
                            r_ack     <= NREQ'(1) << r_grant_id;
                        end else begin
                            r_op <= OP_POLL;
                            if (POLL_GAP == 0) begin
                                r_state   <= S_SETUP;
                                r_penable <= 1'b0;
                                r_pwrite  <= 1'b0;
                                r_paddr   <= ADDR_STATUS;
                                r_pwdata  <= 8'h00;
                            end else begin
                                r_state   <= S_GAP;
                                r_psel    <= 1'b0;
                                r_penable <= 1'b0;
                                r_gap     <= '0;
                            end
                        end
                    end else if (r_wait == WW'(TIMEOUT - 1)) begin
                        r_state   <= S_FINISH;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_err     <= 1'b1;
                        r_ack     <= NREQ'(1) << r_grant_id;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap == 4'(POLL_GAP - 1)) begin
                        r_state   <= S_SETUP;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= 1'b0;
                        r_paddr   <= ADDR_STATUS;
                        r_pwdata  <= 8'h00;
                    end else begin
                        r_gap <= r_gap + 4'd1;
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack      = r_ack;
    assign err      = r_err;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;
    assign PSEL     = r_psel;
    assign PENABLE  = r_penable;
    assign PWRITE   = r_pwrite;
    assign PADDR    = r_paddr;
    assign PWDATA   = r_pwdata;
endmodule
